cplx_op_sequencer: RTL and testbench

//  Command-driven controller for the 32x16 complex data memory (2 async read ports, 1 sync write port).

---
 rtl/cplx_pkg.sv | 36 +++
 rtl/cplx_mac.sv | 59 +++++
 rtl/cplx_op_sequencer.sv | 158 +++++++++++++++
 tb/tb_cplx_op_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cplx_pkg.sv
// Shared types and defaults for the complex-operation sequencer and its MAC.
// A memory word is {re, im}, each a signed two's-complement part.
package cplx_pkg;

   localparam int unsigned CPLX_ADDR_W = 5;
   localparam int unsigned CPLX_PART_W = 8;
   localparam int unsigned CPLX_WORD_W = 2 * CPLX_PART_W;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_MUL  = 2'b10,
      OP_CONJ = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      EXEC  = 2'd2,
      WRITE = 2'd3
   } state_e;

   function automatic logic [CPLX_WORD_W-1:0] cplx_pack(input logic [CPLX_PART_W-1:0] re,
                                                        input logic [CPLX_PART_W-1:0] im);
      return {re, im};
   endfunction

   function automatic logic [CPLX_PART_W-1:0] cplx_re(input logic [CPLX_WORD_W-1:0] w);
      return w[CPLX_WORD_W-1:CPLX_PART_W];
   endfunction

   function automatic logic [CPLX_PART_W-1:0] cplx_im(input logic [CPLX_WORD_W-1:0] w);
      return w[CPLX_PART_W-1:0];
   endfunction

endpackage

// File: rtl/cplx_mac.sv
// Shared signed multiplier with real/imag accumulators for the 4-step complex multiply.
// Step 0: re=ac, 1: re-=bd, 2: im=ad, 3: im+=bc.
module cplx_mac
   import cplx_pkg::*;
#(
   parameter int unsigned PART_W = CPLX_PART_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_en,
   input  logic [1:0]            i_step,
   input  logic                  i_clr,
   input  logic                  i_sub,
   input  logic [PART_W-1:0]     i_a,
   input  logic [PART_W-1:0]     i_b,
   input  logic [PART_W-1:0]     i_c,
   input  logic [PART_W-1:0]     i_d,
   output logic [2*PART_W-1:0]   o_acc_re,
   output logic [2*PART_W-1:0]   o_acc_im
);

   logic [2*PART_W-1:0]        r_acc_re;
   logic [2*PART_W-1:0]        r_acc_im;
   logic [PART_W-1:0]          w_x;
   logic [PART_W-1:0]          w_y;
   logic signed [2*PART_W-1:0] w_prod;
   logic [2*PART_W-1:0]        w_acc_sel;
   logic [2*PART_W-1:0]        w_sum;

   // x alternates a,b,a,b; y follows c,d,d,c across the four steps
   assign w_x       = i_step[0] ? i_b : i_a;
   assign w_y       = (i_step[0] ^ i_step[1]) ? i_d : i_c;
   assign w_prod    = $signed(w_x) * $signed(w_y);
   assign w_acc_sel = i_step[1] ? r_acc_im : r_acc_re;

   always_comb begin
      w_sum = w_acc_sel + w_prod;
      if (i_clr)
         w_sum = w_prod;
      else if (i_sub)
         w_sum = w_acc_sel - w_prod;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc_re <= '0;
         r_acc_im <= '0;
      end else if (i_en) begin
         if (i_step[1])
            r_acc_im <= w_sum;
         else
            r_acc_re <= w_sum;
      end
   end

   assign o_acc_re = r_acc_re;
   assign o_acc_im = r_acc_im;

endmodule

// File: rtl/cplx_op_sequencer.sv
// Command-driven controller for the complex data memory: reads two operands,
// computes ADD/SUB/MUL/CONJ and writes the wrapped result to dst.
module cplx_op_sequencer
   import cplx_pkg::*;
#(
   parameter int unsigned ADDR_W = CPLX_ADDR_W,
   parameter int unsigned PART_W = CPLX_PART_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [ADDR_W-1:0]     cmd_src0,
   input  logic [ADDR_W-1:0]     cmd_src1,
   input  logic [ADDR_W-1:0]     cmd_dst,
   output logic [ADDR_W-1:0]     mem_raddr0,
   output logic [ADDR_W-1:0]     mem_raddr1,
   input  logic [2*PART_W-1:0]   mem_rdata0,
   input  logic [2*PART_W-1:0]   mem_rdata1,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_waddr,
   output logic [2*PART_W-1:0]   mem_wdata,
   output logic                  busy,
   output logic                  done
);

   state_e                r_state;
   state_e                w_next;
   op_e                   r_op;
   logic [ADDR_W-1:0]     r_src0;
   logic [ADDR_W-1:0]     r_src1;
   logic [ADDR_W-1:0]     r_dst;
   logic [2*PART_W-1:0]   r_a;
   logic [2*PART_W-1:0]   r_b;
   logic [1:0]            r_step;
   logic                  w_hs;
   logic                  w_mac_en;
   logic [2*PART_W-1:0]   w_acc_re;
   logic [2*PART_W-1:0]   w_acc_im;
   logic [PART_W-1:0]     w_a_re, w_a_im, w_b_re, w_b_im;
   logic [PART_W-1:0]     w_res_re, w_res_im;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // mem_we/done decode from state so an async reset drops them immediately
   always_comb begin
      w_next    = r_state;
      cmd_ready = 1'b0;
      busy      = 1'b1;
      mem_we    = 1'b0;
      done      = 1'b0;
      case (r_state)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid)
               w_next = READ;
         end
         READ:  w_next = EXEC;
         EXEC: begin
            if (r_op != OP_MUL || r_step == 2'd3)
               w_next = WRITE;
         end
         WRITE: begin
            mem_we = 1'b1;
            done   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_hs = cmd_valid & cmd_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op   <= OP_ADD;
         r_src0 <= '0;
         r_src1 <= '0;
         r_dst  <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_step <= '0;
      end else begin
         if (w_hs) begin
            r_op   <= op_e'(cmd_op);
            r_src0 <= cmd_src0;
            r_src1 <= cmd_src1;
            r_dst  <= cmd_dst;
         end
         if (r_state == READ) begin
            r_a    <= mem_rdata0;
            r_b    <= mem_rdata1;
            r_step <= '0;
         end
         if (r_state == EXEC)
            r_step <= r_step + 2'd1;
      end
   end

   assign w_a_re   = r_a[2*PART_W-1:PART_W];
   assign w_a_im   = r_a[PART_W-1:0];
   assign w_b_re   = r_b[2*PART_W-1:PART_W];
   assign w_b_im   = r_b[PART_W-1:0];
   assign w_mac_en = (r_state == EXEC) && (r_op == OP_MUL);

   cplx_mac #(.PART_W(PART_W)) u_mac (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_en     (w_mac_en),
      .i_step   (r_step),
      .i_clr    (~r_step[0]),
      .i_sub    (r_step == 2'd1),
      .i_a      (w_a_re),
      .i_b      (w_a_im),
      .i_c      (w_b_re),
      .i_d      (w_b_im),
      .o_acc_re (w_acc_re),
      .o_acc_im (w_acc_im)
   );

   // Operands are held through WRITE, so the result is formed combinationally
   always_comb begin
      w_res_re = '0;
      w_res_im = '0;
      case (r_op)
         OP_ADD: begin
            w_res_re = w_a_re + w_b_re;
            w_res_im = w_a_im + w_b_im;
         end
         OP_SUB: begin
            w_res_re = w_a_re - w_b_re;
            w_res_im = w_a_im - w_b_im;
         end
         OP_MUL: begin
            w_res_re = w_acc_re[PART_W-1:0];
            w_res_im = w_acc_im[PART_W-1:0];
         end
         OP_CONJ: begin
            w_res_re = w_a_re;
            w_res_im = '0 - w_a_im;
         end
         default: ;
      endcase
   end

   assign mem_raddr0 = r_src0;
   assign mem_raddr1 = r_src1;
   assign mem_waddr  = r_dst;
   assign mem_wdata  = {w_res_re, w_res_im};

endmodule

// File: tb/tb_cplx_op_sequencer.sv
// Directed bench for cplx_op_sequencer with a behavioural 32x16 memory model.
module tb_cplx_op_sequencer;
   import cplx_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [4:0]  cmd_src0 = '0, cmd_src1 = '0, cmd_dst = '0;
   logic [4:0]  mem_raddr0, mem_raddr1, mem_waddr;
   logic [15:0] mem_rdata0, mem_rdata1, mem_wdata;
   logic        mem_we, busy, done;

   logic [15:0] mem [32];
   logic        pl_en = 1'b0;
   logic [4:0]  pl_addr = '0;
   logic [15:0] pl_data = '0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we)
         mem[mem_waddr] <= mem_wdata;
      else if (pl_en)
         mem[pl_addr] <= pl_data;
   end

   assign mem_rdata0 = mem[mem_raddr0];
   assign mem_rdata1 = mem[mem_raddr1];

   cplx_op_sequencer #(.ADDR_W(5), .PART_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_src0   (cmd_src0),
      .cmd_src1   (cmd_src1),
      .cmd_dst    (cmd_dst),
      .mem_raddr0 (mem_raddr0),
      .mem_raddr1 (mem_raddr1),
      .mem_rdata0 (mem_rdata0),
      .mem_rdata1 (mem_rdata1),
      .mem_we     (mem_we),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
      .done       (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [4:0] a, input logic [15:0] d);
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_data = d;
      @(negedge clk);
      pl_en   = 1'b0;
   endtask

   // Waits for mem_we, returning which negedge after the reference point saw it (0 = timeout)
   task automatic wait_write(output int lat, output bit ready_low);
      lat       = 0;
      ready_low = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (mem_we) begin
            lat = k;
            break;
         end
         if (cmd_ready) ready_low = 1'b0;
      end
   endtask

   task automatic run_cmd(input string tag, input op_e op, input logic [4:0] s0,
                          input logic [4:0] s1, input logic [4:0] d,
                          input int exp_lat, input logic [15:0] exp_w);
      int lat;
      bit rl;
      @(negedge clk);
      chk({tag, "_ready"}, cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_src0  = s0;
      cmd_src1  = s1;
      cmd_dst   = d;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      wait_write(lat, rl);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_busy_rdy"}, rl, 1);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_waddr"}, mem_waddr, d);
      chk({tag, "_wdata"}, mem_wdata, exp_w);
      @(negedge clk);
      chk({tag, "_mem"}, mem[d], exp_w);
      chk({tag, "_ready_after"}, cmd_ready, 1);
   endtask

   initial begin
      int  lat;
      bit  rl;
      bit  saw_we;

      repeat (2) @(negedge clk);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_waddr", mem_waddr, 0);
      chk("rst_raddr0", mem_raddr0, 0);

      preload(5'd0,  cplx_pack(8'h01, 8'h02));
      preload(5'd1,  16'h0304);
      preload(5'd2,  16'h0001);
      preload(5'd3,  16'h0100);
      preload(5'd8,  16'h7F00);
      preload(5'd10, 16'h1234);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_cmd("add",   OP_ADD,  5'd0, 5'd1, 5'd4,  3, 16'h0406);
      run_cmd("sub",   OP_SUB,  5'd0, 5'd1, 5'd5,  3, 16'hFEFE);
      run_cmd("conj",  OP_CONJ, 5'd1, 5'd0, 5'd6,  3, 16'h03FC);
      run_cmd("mul",   OP_MUL,  5'd0, 5'd1, 5'd7,  6, 16'hFB0A);
      run_cmd("mulii", OP_MUL,  5'd2, 5'd2, 5'd11, 6, 16'hFF00);
      run_cmd("wrap",  OP_ADD,  5'd8, 5'd3, 5'd9,  3, 16'h8000);

      // Reset during MUL step 2 must abort with no write to dst
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = OP_MUL;
      cmd_src0  = 5'd0;
      cmd_src1  = 5'd1;
      cmd_dst   = 5'd10;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_mid_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_we", mem_we, 0);
      chk("rst_mid_done", done, 0);
      chk("rst_mid_ready", cmd_ready, 1);
      saw_we = 1'b0;
      repeat (2) @(negedge clk) if (mem_we) saw_we = 1'b1;
      rst_n = 1'b1;
      repeat (10) @(negedge clk) if (mem_we) saw_we = 1'b1;
      chk("rst_mid_no_we", saw_we, 0);
      chk("rst_mid_mem", mem[10], 16'h1234);
      chk("rst_mid_ready_after", cmd_ready, 1);

      // In-place, back-to-back with cmd_valid held high
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = OP_ADD;
      cmd_src0  = 5'd0;
      cmd_src1  = 5'd0;
      cmd_dst   = 5'd0;
      @(posedge clk);
      wait_write(lat, rl);
      chk("b2b1_lat", lat, 3);
      chk("b2b1_wdata", mem_wdata, 16'h0204);
      wait_write(lat, rl);
      cmd_valid = 1'b0;
      chk("b2b2_lat", lat, 4);
      chk("b2b2_wdata", mem_wdata, 16'h0408);
      @(negedge clk);
      chk("b2b2_mem", mem[0], 16'h0408);
      repeat (6) @(negedge clk);
      chk("b2b_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
